miriscv_lsu_buf: RTL and testbench

Parametrised load/store unit between the miriscv core datapath and the data memory port. It replaces the fixed single-cycle load/store path with three things:
- a req/gnt/rvalid memory handshake;
- a posted store buffer of configurable depth;
- misalignment and illegal-size detection.

Data width is configurable (32 or 64 bit). The core stalls through `lsu_stall_req_o` until the request completes.

---
 rtl/miriscv_lsu_buf.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_miriscv_lsu_buf.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu_buf.sv
// miriscv_lsu_buf
// -----------------------------------------------------------------------------
// Load/store unit between the miriscv core datapath and the data memory port.
// It provides three functions:
//   - a req/gnt/rvalid handshake toward data memory;
//   - an optional posted store buffer;
//   - misalignment and illegal-size detection.
//
// Configuration macro: MIRISCV_LSU_STORE_BUFFER_EN
//   defined   : stores are posted into a STB_DEPTH-entry buffer. The buffer
//               drains whenever the FSM is idle, and loads wait for it to
//               empty (there is no forwarding).
//   undefined : stores are blocking. The write goes out directly from IDLE and
//               completes on gnt. STB_DEPTH is ignored.
//
// Parameters
//   DATA_W     memory/register data width, 32 or 64
//   STB_DEPTH  store buffer entries, power of two, >= 1
//
// Ports
//   clk_i, arstn_i    clock (rising edge); asynchronous active-high reset
//   lsu_req_i         core request, held stable while stalled
//   lsu_we_i          1 = store, 0 = load
//   lsu_size_i        funct3 size: B=0 H=1 W=2 D=3 BU=4 HU=5 WU=6
//   lsu_addr_i        byte address
//   lsu_data_i        right-aligned store data
//   lsu_stall_req_o   core must hold its request and PC
//   lsu_data_o        extended load result; zero outside the completion cycle
//   lsu_fault_o       misaligned or illegal access (0-cycle response)
//   data_req_o, data_gnt_i, data_rvalid_i          memory handshake
//   data_we_o, data_be_o, data_addr_o, data_wdata_o memory request fields
//   data_rdata_i      memory read data
// -----------------------------------------------------------------------------
module miriscv_lsu_buf #(
  parameter int DATA_W    = 32,
  parameter int STB_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_size_i,
  input  logic [31:0]           lsu_addr_i,
  input  logic [DATA_W-1:0]     lsu_data_i,
  output logic                  lsu_stall_req_o,
  output logic [DATA_W-1:0]     lsu_data_o,
  output logic                  lsu_fault_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic                  data_we_o,
  output logic [DATA_W/8-1:0]   data_be_o,
  output logic [31:0]           data_addr_o,
  output logic [DATA_W-1:0]     data_wdata_o,
  input  logic [DATA_W-1:0]     data_rdata_i
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LD_REQ  = 2'd1;
  localparam logic [1:0] LD_WAIT = 2'd2;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("miriscv_lsu_buf: DATA_W must be 32 or 64");
  end
  if (STB_DEPTH < 1 || (STB_DEPTH & (STB_DEPTH - 1)) != 0) begin : g_bad_stb_depth
    $error("miriscv_lsu_buf: STB_DEPTH must be a power of two >= 1");
  end

  // D and WU only exist when the port is 64 bits wide.
  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: return 1'b1;
      3'd3, 3'd6:                   return (DATA_W == 64);
      default:                      return 1'b0;
    endcase
  endfunction

  // size[1:0] encodes the access width for both signed and unsigned variants.
  function automatic logic misaligned(input logic [2:0] size, input logic [OFF_W-1:0] off);
    case (size[1:0])
      2'd1:    return off[0];
      2'd2:    return (off[1:0] != 2'b00);
      2'd3:    return (off != '0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [BYTES-1:0] be_mask(input logic [2:0] size, input logic [OFF_W-1:0] off);
    logic [7:0]  base;
    logic [15:0] shifted;
    case (size[1:0])
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    shifted = {8'h00, base} << off;
    return shifted[BYTES-1:0];
  endfunction

  // Replicating the low bytes puts the store data on every lane; the byte
  // enables then select which lane memory actually writes.
  function automatic logic [DATA_W-1:0] wdata_rep(input logic [2:0] size, input logic [DATA_W-1:0] data);
    case (size[1:0])
      2'd0:    return {BYTES{data[7:0]}};
      2'd1:    return {(BYTES/2){data[15:0]}};
      2'd2:    return {(BYTES/4){data[31:0]}};
      default: return data;
    endcase
  endfunction

  // Signed sub-words are extended through a signed size cast.
  function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] size, input logic [OFF_W-1:0] off,
                                                 input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] lane;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    lane = rdata >> {off, 3'b000};
    b_s  = lane[7:0];
    h_s  = lane[15:0];
    w_s  = lane[31:0];
    case (size)
      3'd0:    return DATA_W'(b_s);
      3'd1:    return DATA_W'(h_s);
      3'd2:    return DATA_W'(w_s);
      3'd3:    return lane;
      3'd4:    return DATA_W'(lane[7:0]);
      3'd5:    return DATA_W'(lane[15:0]);
      3'd6:    return DATA_W'(lane[31:0]);
      default: return '0;
    endcase
  endfunction

  logic [1:0]        state, state_nxt;
  logic [OFF_W-1:0]  off;
  logic              legal, mis, fault, is_ld, is_st;
  logic              ld_done, st_done, done;
  logic              drain, ld_clear, st_direct;
  logic [31:0]       addr_al;
  logic [BYTES-1:0]  be_req;
  logic [DATA_W-1:0] wdata_req;
  logic [31:0]       head_addr;
  logic [BYTES-1:0]  head_be;
  logic [DATA_W-1:0] head_wdata;
  logic              req, we;
  logic [BYTES-1:0]  be;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              run;

  // Request decode
  assign off       = lsu_addr_i[OFF_W-1:0];
  assign legal     = size_legal(lsu_size_i);
  assign mis       = misaligned(lsu_size_i, off);
  assign fault     = lsu_req_i & (~legal | mis);
  assign is_ld     = lsu_req_i & legal & ~mis & ~lsu_we_i;
  assign is_st     = lsu_req_i & legal & ~mis & lsu_we_i;
  assign addr_al   = {lsu_addr_i[31:OFF_W], {OFF_W{1'b0}}};
  assign be_req    = be_mask(lsu_size_i, off);
  assign wdata_req = wdata_rep(lsu_size_i, lsu_data_i);

`ifdef MIRISCV_LSU_STORE_BUFFER_EN
  localparam int PTR_W = (STB_DEPTH > 1) ? $clog2(STB_DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]       stb_addr  [STB_DEPTH];
  logic [BYTES-1:0]  stb_be    [STB_DEPTH];
  logic [DATA_W-1:0] stb_wdata [STB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              stb_empty, stb_full, push, pop;

  assign stb_empty = (cnt == '0);
  assign stb_full  = (cnt == (PTR_W+1)'(STB_DEPTH));
  // A full buffer stalls the store even when the head pops this cycle.
  assign push      = is_st & (state == IDLE) & ~stb_full;
  assign drain     = ~stb_empty & (state == IDLE);
  assign pop       = drain & data_gnt_i;
  assign ld_clear  = stb_empty;
  assign st_direct = 1'b0;
  assign st_done   = push;

  assign head_addr  = stb_addr[rd_ptr];
  assign head_be    = stb_be[rd_ptr];
  assign head_wdata = stb_wdata[rd_ptr];

  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      stb_addr[wr_ptr]  <= addr_al;
      stb_be[wr_ptr]    <= be_req;
      stb_wdata[wr_ptr] <= wdata_req;
    end
  end
`else
  assign drain      = 1'b0;
  assign ld_clear   = 1'b1;
  assign st_direct  = is_st;
  assign st_done    = is_st & (state == IDLE) & data_gnt_i;
  assign head_addr  = '0;
  assign head_be    = '0;
  assign head_wdata = '0;
`endif

  // Memory port mux and FSM next state
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    we        = 1'b0;
    be        = '0;
    addr      = '0;
    wdata     = '0;
    ld_done   = 1'b0;
    case (state)
      IDLE: begin
        if (drain) begin
          req   = 1'b1;
          we    = 1'b1;
          addr  = head_addr;
          be    = head_be;
          wdata = head_wdata;
        end else if (is_ld && ld_clear) begin
          req       = 1'b1;
          addr      = addr_al;
          be        = be_req;
          state_nxt = data_gnt_i ? LD_WAIT : LD_REQ;
        end else if (st_direct) begin
          req   = 1'b1;
          we    = 1'b1;
          addr  = addr_al;
          be    = be_req;
          wdata = wdata_req;
        end
      end
      LD_REQ: begin
        req  = 1'b1;
        addr = addr_al;
        be   = be_req;
        if (data_gnt_i) state_nxt = LD_WAIT;
      end
      LD_WAIT: begin
        if (data_rvalid_i) begin
          ld_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Outputs: forced to zero while reset is asserted, even mid-transaction
  // with the core still holding its request.
  assign run  = ~arstn_i;
  assign done = ld_done | st_done;

  assign lsu_stall_req_o = run & lsu_req_i & ~fault & ~done;
  assign lsu_fault_o     = run & fault;
  assign lsu_data_o      = (run && ld_done) ? load_ext(lsu_size_i, off, data_rdata_i) : '0;
  assign data_req_o      = run & req;
  assign data_we_o       = run & we;
  assign data_be_o       = run ? be : '0;
  assign data_addr_o     = run ? addr : '0;
  assign data_wdata_o    = run ? wdata : '0;

endmodule

// File: tb/tb_miriscv_lsu_buf.sv
// Directed testbench for miriscv_lsu_buf (DATA_W=32, STB_DEPTH=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 time
// units later, well before the falling edge.
module tb_miriscv_lsu_buf;
  localparam int DATA_W = 32;

  logic              clk;
  logic              arstn;
  logic              lsu_req, lsu_we;
  logic [2:0]        lsu_size;
  logic [31:0]       lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              lsu_stall;
  logic [31:0]       lsu_rdata;
  logic              lsu_fault;
  logic              data_req, data_gnt, data_rvalid, data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_addr, data_wdata, data_rdata;

  int tests = 0;
  int fails = 0;

  miriscv_lsu_buf #(.DATA_W(DATA_W), .STB_DEPTH(2)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .lsu_req_i       (lsu_req),
    .lsu_we_i        (lsu_we),
    .lsu_size_i      (lsu_size),
    .lsu_addr_i      (lsu_addr),
    .lsu_data_i      (lsu_wdata),
    .lsu_stall_req_o (lsu_stall),
    .lsu_data_o      (lsu_rdata),
    .lsu_fault_o     (lsu_fault),
    .data_req_o      (data_req),
    .data_gnt_i      (data_gnt),
    .data_rvalid_i   (data_rvalid),
    .data_we_o       (data_we),
    .data_be_o       (data_be),
    .data_addr_o     (data_addr),
    .data_wdata_o    (data_wdata),
    .data_rdata_i    (data_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one load and records what the memory port and core side show.
  task automatic run_load(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] rd,
                          input int gdly, input int rdly,
                          output logic [3:0] be_g, output logic [31:0] addr_g,
                          output logic [31:0] dout, output int stalls,
                          output logic leak, output logic finished);
    be_g = '0; addr_g = '0; dout = '0; stalls = 0; leak = 1'b0; finished = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = sz; lsu_addr = a; lsu_wdata = '0;
    for (int c = 0; c < 20 && !finished; c++) begin
      data_gnt    = (c == gdly);
      data_rvalid = (c == gdly + 1 + rdly);
      data_rdata  = data_rvalid ? rd : 32'hDEAD_BEEF;
      #3;
      if (data_req && data_gnt) begin be_g = data_be; addr_g = data_addr; end
      if (lsu_stall) begin
        stalls++;
        if (lsu_rdata !== 32'h0) leak = 1'b1;
      end else begin
        dout = lsu_rdata;
        finished = 1'b1;
      end
      @(posedge clk); #1;
    end
    lsu_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
  endtask

  task automatic test_reset();
    arstn = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = '0; lsu_addr = '0; lsu_wdata = '0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
    repeat (2) @(posedge clk);
    #1; #3;
    tests++; if ({lsu_stall, lsu_fault, data_req, data_we} !== 4'b0) begin fails++;
      $display("FAIL rst_ctrl got %b expected 0000", {lsu_stall, lsu_fault, data_req, data_we}); end
    tests++; if ({data_be, data_addr, data_wdata, lsu_rdata} !== '0) begin fails++;
      $display("FAIL rst_bus got be=%h addr=%h wd=%h rd=%h expected all 0", data_be, data_addr, data_wdata, lsu_rdata); end
    @(posedge clk); #1;
    arstn = 1'b0;
    #3;
    tests++; if ({lsu_stall, lsu_fault, data_req, data_we, data_be, data_addr} !== '0) begin fails++;
      $display("FAIL rst_release got stall=%b req=%b be=%h addr=%h expected 0", lsu_stall, data_req, data_be, data_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_lw_aligned();
    logic [3:0] be_g; logic [31:0] addr_g, dout; int stalls; logic leak, fin;
    run_load(32'h104, 3'd2, 32'h8000_00F0, 0, 0, be_g, addr_g, dout, stalls, leak, fin);
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL lw_done got %b expected 1", fin); end
    tests++; if (stalls !== 1) begin fails++; $display("FAIL lw_stalls got %0d expected 1", stalls); end
    tests++; if (dout !== 32'h8000_00F0) begin fails++; $display("FAIL lw_data got %h expected 800000f0", dout); end
    tests++; if (be_g !== 4'hF) begin fails++; $display("FAIL lw_be got %h expected f", be_g); end
    tests++; if (addr_g !== 32'h104) begin fails++; $display("FAIL lw_addr got %h expected 00000104", addr_g); end
    tests++; if (leak !== 1'b0) begin fails++; $display("FAIL lw_data_early got %b expected 0", leak); end
  endtask

  task automatic test_lb_lane();
    logic [3:0] be_g; logic [31:0] addr_g, dout; int stalls; logic leak, fin;
    // LB with one cycle of gnt delay and one of rvalid delay.
    run_load(32'h103, 3'd0, 32'h8012_3456, 1, 1, be_g, addr_g, dout, stalls, leak, fin);
    tests++; if (dout !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_data got %h expected ffffff80", dout); end
    tests++; if (be_g !== 4'h8) begin fails++; $display("FAIL lb_be got %h expected 8", be_g); end
    tests++; if (addr_g !== 32'h100) begin fails++; $display("FAIL lb_addr got %h expected 00000100", addr_g); end
    tests++; if (stalls !== 3) begin fails++; $display("FAIL lb_stalls got %0d expected 3", stalls); end
    tests++; if (leak !== 1'b0) begin fails++; $display("FAIL lb_data_early got %b expected 0", leak); end
    run_load(32'h103, 3'd4, 32'h8012_3456, 0, 0, be_g, addr_g, dout, stalls, leak, fin);
    tests++; if (dout !== 32'h0000_0080) begin fails++; $display("FAIL lbu_data got %h expected 00000080", dout); end
    tests++; if (be_g !== 4'h8) begin fails++; $display("FAIL lbu_be got %h expected 8", be_g); end
    run_load(32'h102, 3'd1, 32'h8001_7777, 0, 0, be_g, addr_g, dout, stalls, leak, fin);
    tests++; if (dout !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_data got %h expected ffff8001", dout); end
    tests++; if (be_g !== 4'hC) begin fails++; $display("FAIL lh_be got %h expected c", be_g); end
    run_load(32'h102, 3'd5, 32'h8001_7777, 0, 0, be_g, addr_g, dout, stalls, leak, fin);
    tests++; if (dout !== 32'h0000_8001) begin fails++; $display("FAIL lhu_data got %h expected 00008001", dout); end
    run_load(32'h101, 3'd0, 32'h0000_7F00, 0, 0, be_g, addr_g, dout, stalls, leak, fin);
    tests++; if (dout !== 32'h0000_007F) begin fails++; $display("FAIL lb_pos_data got %h expected 0000007f", dout); end
    tests++; if (be_g !== 4'h2) begin fails++; $display("FAIL lb_pos_be got %h expected 2", be_g); end
  endtask

  task automatic test_misaligned();
    logic        we_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  sz_t [4] = '{3'd1, 3'd3, 3'd7, 3'd2};
    logic [31:0] ad_t [4] = '{32'h101, 32'h100, 32'h100, 32'h102};
    for (int i = 0; i < 4; i++) begin
      lsu_req = 1'b1; lsu_we = we_t[i]; lsu_size = sz_t[i]; lsu_addr = ad_t[i]; lsu_wdata = 32'h0000_BEEF;
      data_gnt = 1'b1;
      #3;
      tests++; if (lsu_fault !== 1'b1) begin fails++; $display("FAIL fault_%0d got %b expected 1", i, lsu_fault); end
      tests++; if ({data_req, lsu_stall} !== 2'b00) begin fails++;
        $display("FAIL fault_%0d_req_stall got %b expected 00", i, {data_req, lsu_stall}); end
      @(posedge clk); #1;
      lsu_req = 1'b0; data_gnt = 1'b0;
      #3;
      tests++; if ({lsu_fault, data_req} !== 2'b00) begin fails++;
        $display("FAIL fault_%0d_after got %b expected 00", i, {lsu_fault, data_req}); end
      @(posedge clk); #1;
    end
  endtask

`ifdef MIRISCV_LSU_STORE_BUFFER_EN
  task automatic test_stb_fill();
    logic       stall_exp [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       req_exp   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] be_exp    [7] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h0};
    logic [7:0] dat_t     [3] = '{8'h01, 8'h02, 8'h03};
    int st;
    st = 0;
    for (int c = 0; c < 7; c++) begin
      lsu_req = (st < 3); lsu_we = 1'b1; lsu_size = 3'd0;
      lsu_addr = 32'h200 + 32'(st); lsu_wdata = {24'h0, dat_t[(st < 3) ? st : 2]};
      data_gnt = (c >= 3 && c <= 5);
      #3;
      tests++; if (lsu_stall !== stall_exp[c]) begin fails++;
        $display("FAIL stb_stall_c%0d got %b expected %b", c, lsu_stall, stall_exp[c]); end
      tests++; if ({data_req, data_we, data_be} !== {req_exp[c], req_exp[c], be_exp[c]}) begin fails++;
        $display("FAIL stb_port_c%0d got req=%b we=%b be=%h expected req=%b be=%h", c, data_req, data_we, data_be, req_exp[c], be_exp[c]); end
      if (c == 1) begin
        tests++; if ({data_addr, data_wdata} !== {32'h200, 32'h0101_0101}) begin fails++;
          $display("FAIL stb_head got addr=%h wd=%h expected 00000200 01010101", data_addr, data_wdata); end
      end
      if (c == 5) begin
        tests++; if ({data_addr, data_wdata} !== {32'h200, 32'h0303_0303}) begin fails++;
          $display("FAIL stb_tail got addr=%h wd=%h expected 00000200 03030303", data_addr, data_wdata); end
      end
      if (lsu_req && !lsu_stall) st++;
      @(posedge clk); #1;
    end
    lsu_req = 1'b0; data_gnt = 1'b0;
  endtask
`else
  task automatic test_store_blocking();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 3'd2; lsu_addr = 32'h300; lsu_wdata = 32'h1122_3344;
    data_gnt = 1'b0;
    #3;
    tests++; if ({data_req, data_we, data_be} !== {1'b1, 1'b1, 4'hF}) begin fails++;
      $display("FAIL sw_port got req=%b we=%b be=%h expected 1 1 f", data_req, data_we, data_be); end
    tests++; if ({data_addr, data_wdata} !== {32'h300, 32'h1122_3344}) begin fails++;
      $display("FAIL sw_fields got addr=%h wd=%h expected 00000300 11223344", data_addr, data_wdata); end
    tests++; if (lsu_stall !== 1'b1) begin fails++; $display("FAIL sw_stall_nogrant got %b expected 1", lsu_stall); end
    @(posedge clk); #1;
    data_gnt = 1'b1;
    #3;
    tests++; if ({data_req, lsu_stall} !== 2'b10) begin fails++;
      $display("FAIL sw_grant got req=%b stall=%b expected 1 0", data_req, lsu_stall); end
    @(posedge clk); #1;
    lsu_size = 3'd0; lsu_addr = 32'h202; lsu_wdata = 32'h0000_00A5;
    #3;
    tests++; if ({data_be, data_addr, data_wdata, lsu_stall} !== {4'h4, 32'h200, 32'hA5A5_A5A5, 1'b0}) begin fails++;
      $display("FAIL sb_fields got be=%h addr=%h wd=%h stall=%b expected 4 00000200 a5a5a5a5 0", data_be, data_addr, data_wdata, lsu_stall); end
    @(posedge clk); #1;
    lsu_size = 3'd1; lsu_addr = 32'h106; lsu_wdata = 32'h1234_BEEF;
    #3;
    tests++; if ({data_be, data_addr, data_wdata, lsu_stall} !== {4'hC, 32'h104, 32'hBEEF_BEEF, 1'b0}) begin fails++;
      $display("FAIL sh_fields got be=%h addr=%h wd=%h stall=%b expected c 00000104 beefbeef 0", data_be, data_addr, data_wdata, lsu_stall); end
    @(posedge clk); #1;
    lsu_req = 1'b0; data_gnt = 1'b0;
    #3;
    tests++; if (data_req !== 1'b0) begin fails++; $display("FAIL st_idle_req got %b expected 0", data_req); end
    @(posedge clk); #1;
  endtask
`endif

  // SW then LW to the same address; memory grants each request after two
  // cycles and holds the word in a one-location model.
  task automatic test_load_behind_store();
    logic [31:0] mem_word, got;
    int req_age, phase, wr_at, ld_at;
    logic ld_pend, ld_pend_nxt, order_ok;
    mem_word = '0; got = '0; req_age = 0; phase = 0; wr_at = -1; ld_at = -1; ld_pend = 1'b0;
    for (int c = 0; c < 30 && phase != 2; c++) begin
      lsu_req = 1'b1; lsu_we = (phase == 0); lsu_size = 3'd2; lsu_addr = 32'h300; lsu_wdata = 32'hCAFE_F00D;
      data_gnt = (req_age >= 2); data_rvalid = ld_pend; data_rdata = ld_pend ? mem_word : 32'h0BAD_0BAD;
      #3;
      ld_pend_nxt = 1'b0;
      if (data_req) begin
        if (data_gnt) begin
          if (data_we) begin
            wr_at = c;
            for (int b = 0; b < 4; b++) if (data_be[b]) mem_word[8*b +: 8] = data_wdata[8*b +: 8];
          end else begin
            ld_at = c;
            ld_pend_nxt = 1'b1;
          end
          req_age = 0;
        end else begin
          req_age++;
        end
      end
      if (phase == 1 && !lsu_stall) begin got = lsu_rdata; phase = 2; end
      else if (phase == 0 && !lsu_stall) phase = 1;
      ld_pend = ld_pend_nxt;
      @(posedge clk); #1;
    end
    lsu_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
    order_ok = (wr_at >= 0) && (ld_at > wr_at);
    tests++; if (phase !== 2) begin fails++; $display("FAIL lbs_complete got phase %0d expected 2", phase); end
    tests++; if (order_ok !== 1'b1) begin fails++; $display("FAIL lbs_order got wr_at=%0d ld_at=%0d expected write first", wr_at, ld_at); end
    tests++; if (mem_word !== 32'hCAFE_F00D) begin fails++; $display("FAIL lbs_mem got %h expected cafef00d", mem_word); end
    tests++; if (got !== 32'hCAFE_F00D) begin fails++; $display("FAIL lbs_data got %h expected cafef00d", got); end
  endtask

  task automatic test_reset_mid_load();
    logic [3:0] be_g; logic [31:0] addr_g, dout; int stalls; logic leak, fin;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h104; data_gnt = 1'b1;
    #3;
    tests++; if (data_req !== 1'b1) begin fails++; $display("FAIL rml_issue got %b expected 1", data_req); end
    @(posedge clk); #1;
    data_gnt = 1'b0;
    #3;
    tests++; if ({lsu_stall, data_req} !== 2'b10) begin fails++;
      $display("FAIL rml_wait got stall=%b req=%b expected 1 0", lsu_stall, data_req); end
    arstn = 1'b1;
    #1;
    tests++; if ({lsu_stall, lsu_fault, data_req, data_we, data_be, data_addr, data_wdata, lsu_rdata} !== '0) begin fails++;
      $display("FAIL rml_outputs got stall=%b req=%b be=%h addr=%h expected all 0", lsu_stall, data_req, data_be, data_addr); end
    @(posedge clk); #1;
    arstn = 1'b0; lsu_req = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h1234_5678;
    #3;
    tests++; if ({lsu_rdata, lsu_stall} !== 33'h0) begin fails++;
      $display("FAIL rml_stale_rvalid got data=%h stall=%b expected 0 0", lsu_rdata, lsu_stall); end
    @(posedge clk); #1;
    data_rvalid = 1'b0; data_rdata = '0;
    run_load(32'h108, 3'd2, 32'h5A5A_5A5A, 0, 0, be_g, addr_g, dout, stalls, leak, fin);
    tests++; if ({dout, 8'(stalls)} !== {32'h5A5A_5A5A, 8'd1}) begin fails++;
      $display("FAIL rml_next_load got data=%h stalls=%0d expected 5a5a5a5a 1", dout, stalls); end
  endtask

  initial begin
    test_reset();
    test_lw_aligned();
    test_lb_lane();
    test_misaligned();
`ifdef MIRISCV_LSU_STORE_BUFFER_EN
    test_stb_fill();
`else
    test_store_blocking();
`endif
    test_load_behind_store();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
